// File: rtl/uart_rx_frame_if.sv
// Signal bundle between the UART receive engine and its line/config driver and
// result consumer. The master drives the line and config; the slave is the receiver.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  RX_BUSY;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive engine: oversampled start qualification, 3-sample majority
// data recovery, optional parity and stop checking with one-cycle result strobes.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input logic            CLK,
    input logic            RST,
    uart_rx_frame_if.slave rx_if
);
    localparam int BCW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [5:0]            edge_cnt_q, prescale_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic                  par_en_q, par_typ_q, par_fail_q;
    logic [2:0]            samples_q;
    logic [DATA_WIDTH-1:0] shift_q, p_data_q;
    logic                  data_valid_q, par_err_q, stp_err_q;
    logic                  rx_busy;

    logic [5:0] half;
    logic       bit_end, in_window, vote, last_data;

    assign half      = {1'b0, prescale_q[5:1]};
    assign bit_end   = (edge_cnt_q == prescale_q - 6'd1);
    assign in_window = (edge_cnt_q >= half - 6'd1) && (edge_cnt_q <= half + 6'd1);
    assign vote      = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                       (samples_q[1] & samples_q[2]);
    assign last_data = (bit_cnt_q == BCW'(DATA_WIDTH - 1));

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rx_s_q) state_d = START;
            START:   if (bit_end) state_d = vote ? IDLE : DATA;
            DATA:    if (bit_end && last_data) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state_q != IDLE);
    end

    // Both synchronizer flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_if.RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt_q   <= '0;
            prescale_q   <= '0;
            bit_cnt_q    <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail_q   <= 1'b0;
            samples_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            if (state_q == IDLE) begin
                // The detection cycle is edge 0 of the start bit, hence the load of 1.
                if (!rx_s_q) begin
                    edge_cnt_q <= 6'd1;
                    prescale_q <= rx_if.PRESCALE;
                    par_en_q   <= rx_if.PAR_EN;
                    par_typ_q  <= rx_if.PAR_TYP;
                    par_fail_q <= 1'b0;
                    bit_cnt_q  <= '0;
                end
            end else begin
                edge_cnt_q <= bit_end ? 6'd0 : edge_cnt_q + 6'd1;
                if (in_window) samples_q <= {samples_q[1:0], rx_s_q};
                if (bit_end) begin
                    unique case (state_q)
                        DATA: begin
                            shift_q   <= {vote, shift_q[DATA_WIDTH-1:1]};
                            bit_cnt_q <= last_data ? '0 : bit_cnt_q + BCW'(1);
                        end
                        PARITY: par_fail_q <= (vote != (^shift_q ^ par_typ_q));
                        STOP: begin
                            data_valid_q <= !par_fail_q && vote;
                            par_err_q    <= par_fail_q;
                            stp_err_q    <= !vote;
                            if (!par_fail_q && vote) p_data_q <= shift_q;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.DATA_VALID = data_valid_q;
    assign rx_if.PAR_ERR    = par_err_q;
    assign rx_if.STP_ERR    = stp_err_q;
    assign rx_if.RX_BUSY    = rx_busy;
endmodule
